mac4_array: RTL
===============

# mac4_array

Four-lane multiply-accumulate engine that feeds the write-back stage. For each job it streams N_TAPS 8-bit samples against four coefficient columns read from a synchronous coefficient ROM. It produces four 18-bit results on MU1..MU4 and a one-cycle `web` pulse, which the write-back stage uses to serialise the results into data RAM.

## Interface
- N_TAPS, 8, samples per job; power of two, 2..8
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  job request; sampled only in IDLE
- c_base  in  5  coefficient bank; latched on accepted start
- x_in  in  8  sample, unsigned
- x_valid  in  1  sample valid
- x_ready  out  1  sample accepted when x_valid && x_ready
- c_addr  out  8  ROM address {c_base_q, tap[2:0]}; tap zero-extended when N_TAPS<8
- c_data  in  32  ROM data, valid one cycle after c_addr; byte i (unsigned) → lane i+1
- MU1..MU4  out  18 each  lane results, held until next job completes
- web  out  1  one-cycle pulse, results valid
- busy  out  1  high in every state except IDLE

## Operation
- States:
  - IDLE: start=1 → RUN; clear accumulators, tap=0, latch c_base.
  - RUN: x_ready=1. Each accept registers x_in into x_q, drives c_addr={c_base_q,tap}, increments tap, sets p_valid.
    - On the N_TAPS-th accept → DRAIN.
  - DRAIN: x_ready=0; last product accumulates; MU registers load → DONE.
  - DONE: web=1 for exactly one cycle → IDLE.
- Pipeline: p_valid in cycle t+1 adds x_q*c_data[8i+7:8i] to acc_i, for every accept in cycle t.
- Arithmetic:
  - Product is 16 bits.
  - Accumulator is 16+log2(N_TAPS) bits, so it never overflows internally.
  - Output reduces to 18 bits per Configuration.
- start outside IDLE: ignored.
- x_valid outside RUN: ignored; no state change.
- Gaps in x_valid: pipeline bubbles; the result is identical.
- MU1..MU4 change only at the DRAIN→DONE edge. They stay stable for all cycles until the next DONE, which is ≥N_TAPS+3 cycles later. This satisfies write-back's 4-cycle read of MU1 after `web`.
- Reset at any time: all state, accumulators and MU registers clear; no `web` is emitted for the aborted job.
- Reset values: x_ready=0, c_addr=0, MU1..MU4=0, web=0, busy=0; state IDLE.

## Timing
- start high in cycle 0 → RUN in cycle 1, x_ready=1.
- With x_valid constantly high: accepts in cycles 1..N_TAPS, DRAIN in N_TAPS+1, web in N_TAPS+2 (cycle 10 for default).
- Minimum start-to-web latency: N_TAPS+2 cycles. Each x_valid stall cycle adds one.
- Earliest next start: cycle after web (IDLE). Minimum web-to-web spacing: N_TAPS+3.
- c_addr is registered. It changes only on accepts and holds between them.

## Configuration
- MAC4_SAT_EN defined: each MU = min(acc, 18'h3FFFF).
- MAC4_SAT_EN undefined: each MU = acc[17:0] (wrap).
- Identical results whenever acc < 2^18.

## Structure
- Package mac4_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - MU_W=18, X_W=8, C_W=8
  - default N_TAPS
  - ACC_W function of N_TAPS
- Sub-module mac_lane, instantiated 4×:
  - inputs: clear, enable, x_q, 8-bit coefficient
  - holds acc_i
  - provides the saturated or wrapped 18-bit view

## Test plan
- x=1..8 continuous; lanes c=(1,2,0,255) for all taps → web at cycle 10; MU1=36, MU2=72, MU3=0, MU4=9180.
- x=255, c=255 all lanes, 8 taps → with MAC4_SAT_EN MU=0x3FFFF; without MU=0x3F008.
- Same as first, x_valid low on alternate cycles → identical MU values; web at cycle 17.
- start pulsed again in RUN and DRAIN → ignored; single web; c_base change mid-job has no effect on c_addr.
- rst low during RUN after 4 accepts → all outputs 0 immediately; no web. New job afterwards gives correct results.
- Two back-to-back jobs (start in cycle after web) → first MU values stable ≥11 cycles after first web; second web carries new values.

Source files
------------

// File: rtl/mac4_pkg.sv
// mac4_pkg: shared widths, FSM state type and accumulator sizing for the
// mac4_array multiply-accumulate engine.
package mac4_pkg;

  localparam int unsigned MU_W       = 18;  // lane result width
  localparam int unsigned X_W        = 8;   // sample width
  localparam int unsigned C_W        = 8;   // coefficient width
  localparam int unsigned P_W        = 16;  // product width
  localparam int unsigned LANES      = 4;
  localparam int unsigned TAP_W      = 3;   // tap field of the ROM address
  localparam int unsigned BASE_W     = 5;   // coefficient bank field
  localparam int unsigned ADDR_W     = BASE_W + TAP_W;
  localparam int unsigned N_TAPS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Accumulator is wide enough that N_TAPS full-scale products never overflow.
  function automatic int unsigned acc_w(input int unsigned n_taps);
    return P_W + $clog2(n_taps);
  endfunction

endpackage

// File: rtl/mac_lane.sv
// mac_lane: one multiply-accumulate lane.
//   clk, rst      clock, async active-low reset
//   clear         zero the accumulator (job start)
//   enable        add x_q*coef this cycle
//   x_q, coef     unsigned sample and coefficient
//   mu_c          18-bit view of the accumulator after this cycle's update
// Build option MAC4_SAT_EN: saturate the view at 18'h3FFFF instead of wrapping.
module mac_lane
  import mac4_pkg::*;
#(
  parameter int unsigned ACC_W = acc_w(N_TAPS_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [X_W-1:0]   x_q,
  input  logic [C_W-1:0]   coef,
  output logic [MU_W-1:0]  mu_c
);

  logic [P_W-1:0]   prod;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

  // Product and next accumulator value.
  always_comb begin
    prod  = P_W'(x_q) * P_W'(coef);
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (enable) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Reduce to the result width; the view is taken from acc_d so the top can
  // load results on the same edge the final product lands.
  generate
    if (ACC_W > MU_W) begin : g_wide
`ifdef MAC4_SAT_EN
      assign mu_c = (|acc_d[ACC_W-1:MU_W]) ? {MU_W{1'b1}} : acc_d[MU_W-1:0];
`else
      assign mu_c = acc_d[MU_W-1:0];
`endif
    end else begin : g_narrow
      assign mu_c = MU_W'(acc_d);
    end
  endgenerate

endmodule

// File: rtl/mac4_array.sv
// mac4_array: four-lane multiply-accumulate engine feeding write-back.
//   clk, rst        clock, async active-low reset
//   start, c_base   job request (taken in IDLE) and coefficient bank
//   x_in, x_valid,  sample stream; accepted when x_valid && x_ready
//   x_ready
//   c_addr, c_data  coefficient ROM address {bank, tap} and returned word,
//                   byte i feeding lane i+1
//   MU1..MU4        lane results, held until the next job completes
//   web             one-cycle pulse when results are valid
//   busy            high whenever not IDLE
// Build option MAC4_SAT_EN: results saturate at 18'h3FFFF instead of wrapping.
module mac4_array
  import mac4_pkg::*;
#(
  parameter int unsigned N_TAPS = N_TAPS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BASE_W-1:0] c_base,
  input  logic [X_W-1:0]    x_in,
  input  logic              x_valid,
  output logic              x_ready,
  output logic [ADDR_W-1:0] c_addr,
  input  logic [31:0]       c_data,
  output logic [MU_W-1:0]   MU1,
  output logic [MU_W-1:0]   MU2,
  output logic [MU_W-1:0]   MU3,
  output logic [MU_W-1:0]   MU4,
  output logic              web,
  output logic              busy
);

  localparam int unsigned      ACC_W    = acc_w(N_TAPS);
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(N_TAPS - 1);

  state_e            state_q;
  state_e            state_d;
  logic              accept_c;
  logic              clear_c;
  logic              load_c;
  logic [X_W-1:0]    x_q;
  logic [TAP_W-1:0]  tap_q;
  logic [BASE_W-1:0] c_base_q;
  logic              p_valid_q;
  logic [MU_W-1:0]   mu_next [LANES];

  // Next-state and per-cycle strobes.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    clear_c  = 1'b0;
    load_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          clear_c = 1'b1;
        end
      end
      RUN: begin
        accept_c = x_valid && x_ready;
        if (accept_c && (tap_q == TAP_LAST)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        load_c  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and registered outputs; status flags follow the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_ready   <= 1'b0;
      busy      <= 1'b0;
      web       <= 1'b0;
      x_q       <= '0;
      tap_q     <= '0;
      c_base_q  <= '0;
      c_addr    <= '0;
      p_valid_q <= 1'b0;
      MU1       <= '0;
      MU2       <= '0;
      MU3       <= '0;
      MU4       <= '0;
    end else begin
      x_ready   <= (state_d == RUN);
      busy      <= (state_d != IDLE);
      web       <= (state_d == DONE);
      p_valid_q <= accept_c;
      if (clear_c) begin
        tap_q    <= '0;
        c_base_q <= c_base;
      end
      if (accept_c) begin
        x_q    <= x_in;
        c_addr <= {c_base_q, tap_q};
        tap_q  <= tap_q + TAP_W'(1);
      end
      if (load_c) begin
        MU1 <= mu_next[0];
        MU2 <= mu_next[1];
        MU3 <= mu_next[2];
        MU4 <= mu_next[3];
      end
    end
  end

  // One lane per coefficient byte; the product of an accept lands the next cycle.
  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      mac_lane #(
        .ACC_W (ACC_W)
      ) u_lane (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear_c),
        .enable (p_valid_q),
        .x_q    (x_q),
        .coef   (c_data[C_W*i +: C_W]),
        .mu_c   (mu_next[i])
      );
    end
  endgenerate

endmodule
